// File: rtl/flag_stack.sv
// rtl/flag_stack.sv - ALU condition flag register with sticky bits and a LIFO save/restore stack
module flag_stack #(
  parameter int                   NUM_FLAGS   = 4,
  parameter int                   DEPTH       = 4,
  parameter logic [NUM_FLAGS-1:0] STICKY_MASK = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_FLAGS-1:0]       flagsIn,
  input  logic                       setFlags,
  input  logic [NUM_FLAGS-1:0]       flagMask,
  input  logic                       clearSticky,
  input  logic                       push,
  input  logic                       pop,
  output logic [NUM_FLAGS-1:0]       flagsOut,
  output logic [$clog2(DEPTH+1)-1:0] depthCount,
  output logic                       full,
  output logic                       empty,
  output logic                       stackErr
);

  localparam int DW = $clog2(DEPTH+1);

  logic [NUM_FLAGS-1:0] flags_q, flags_d;
  logic [DW-1:0]        depth_q, depth_d;
  logic                 err_q, err_d;
  logic [NUM_FLAGS-1:0] stack_q [DEPTH];
  logic [NUM_FLAGS-1:0] stack_d [DEPTH];

  logic                 is_full, is_empty;
  logic                 do_push, do_pop, do_xchg, bad_op;
  logic [DW-1:0]        top_idx;
  logic [NUM_FLAGS-1:0] top_val, wen, base, upd;

  assign is_full  = (depth_q == DW'(DEPTH));
  assign is_empty = (depth_q == '0);

  always_comb begin
    do_push = push & ~pop & ~is_full;
    do_pop  = pop & ~push & ~is_empty;
    do_xchg = push & pop & ~is_empty;
    bad_op  = (push & ~pop & is_full) | (pop & is_empty);
    top_idx = depth_q - DW'(1);

    top_val = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (DW'(i) == top_idx) top_val = stack_q[i];
    end

    // Sticky bits are cleared first, then ORed with any enabled new value
    wen  = {NUM_FLAGS{setFlags}} & flagMask;
    base = clearSticky ? (flags_q & ~STICKY_MASK) : flags_q;
    upd  = (base & ~wen)
         | (wen & ~STICKY_MASK & flagsIn)
         | (wen & STICKY_MASK & (base | flagsIn));

    flags_d = upd;
    depth_d = depth_q;
    err_d   = err_q | bad_op;
    stack_d = stack_q;

    if (do_push) begin
      depth_d = depth_q + DW'(1);
      for (int i = 0; i < DEPTH; i++) begin
        if (DW'(i) == depth_q) stack_d[i] = flags_q;
      end
    end else if (do_pop) begin
      flags_d = top_val;
      depth_d = top_idx;
    end else if (do_xchg) begin
      flags_d = top_val;
      for (int i = 0; i < DEPTH; i++) begin
        if (DW'(i) == top_idx) stack_d[i] = flags_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q <= '0;
      depth_q <= '0;
      err_q   <= 1'b0;
    end else begin
      flags_q <= flags_d;
      depth_q <= depth_d;
      err_q   <= err_d;
    end
  end

  // Entry contents need no reset; depth_q gates what is observable
  always_ff @(posedge clk) begin
    if (!reset) stack_q <= stack_d;
  end

  assign flagsOut   = flags_q;
  assign depthCount = depth_q;
  assign full       = is_full;
  assign empty      = is_empty;
  assign stackErr   = err_q;

endmodule

// File: tb/tb_flag_stack.sv
// tb/tb_flag_stack.sv - directed self-checking bench for flag_stack
module tb_flag_stack;

  logic       clk = 1'b0;
  logic       reset, setFlags, clearSticky, push, pop;
  logic [3:0] flagsIn, flagMask;

  logic [3:0] f_out, s_out;
  logic [2:0] d_cnt, s_cnt;
  logic       d_full, d_empty, d_err, s_full, s_empty, s_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  flag_stack dut (
    .clk(clk), .reset(reset), .flagsIn(flagsIn), .setFlags(setFlags),
    .flagMask(flagMask), .clearSticky(clearSticky), .push(push), .pop(pop),
    .flagsOut(f_out), .depthCount(d_cnt), .full(d_full), .empty(d_empty),
    .stackErr(d_err)
  );

  flag_stack #(.STICKY_MASK(4'b0010)) dut_s (
    .clk(clk), .reset(reset), .flagsIn(flagsIn), .setFlags(setFlags),
    .flagMask(flagMask), .clearSticky(clearSticky), .push(push), .pop(pop),
    .flagsOut(s_out), .depthCount(s_cnt), .full(s_full), .empty(s_empty),
    .stackErr(s_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic sf, input logic [3:0] m,
                      input logic [3:0] fi, input logic c, input logic pu, input logic po);
    reset = r; setFlags = sf; flagMask = m; flagsIn = fi;
    clearSticky = c; push = pu; pop = po;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [3:0] f, input logic [2:0] d,
                           input logic fu, input logic em, input logic er);
    chk({tag, " flags"}, 32'(f_out), 32'(f));
    chk({tag, " depth"}, 32'(d_cnt), 32'(d));
    chk({tag, " full"},  32'(d_full), 32'(fu));
    chk({tag, " empty"}, 32'(d_empty), 32'(em));
    chk({tag, " err"},   32'(d_err), 32'(er));
  endtask

  initial begin
    step(1, 0, 4'h0, 4'h0, 0, 0, 0);
    step(1, 1, 4'hF, 4'hF, 0, 1, 0);
    chk_state("reset", 4'b0000, 3'd0, 0, 1, 0);

    step(0, 1, 4'b1111, 4'b1010, 0, 0, 0);
    chk("set all", 32'(f_out), 32'(4'b1010));
    step(0, 1, 4'b0001, 4'b0101, 0, 0, 0);
    chk("set bit0", 32'(f_out), 32'(4'b1011));
    step(0, 0, 4'b1111, 4'b0000, 0, 0, 0);
    chk("hold", 32'(f_out), 32'(4'b1011));

    step(0, 1, 4'b1111, 4'b1100, 0, 0, 0);
    step(0, 0, 4'b0000, 4'b0000, 0, 1, 0);
    chk_state("push1", 4'b1100, 3'd1, 0, 0, 0);
    step(0, 1, 4'b1111, 4'b0011, 0, 0, 0);
    chk("set 0011", 32'(f_out), 32'(4'b0011));
    step(0, 0, 4'b0000, 4'b0000, 0, 0, 1);
    chk_state("pop1", 4'b1100, 3'd0, 0, 1, 0);

    step(0, 1, 4'b1111, 4'b0110, 0, 1, 0);
    chk_state("push+set", 4'b0110, 3'd1, 0, 0, 0);
    step(0, 1, 4'b1111, 4'b1111, 0, 0, 1);
    chk_state("pop overrides set", 4'b1100, 3'd0, 0, 1, 0);

    step(0, 1, 4'b1111, 4'b1000, 0, 0, 0);
    step(0, 0, 4'b0000, 4'b0000, 0, 1, 0);
    step(0, 1, 4'b1111, 4'b0001, 0, 0, 0);
    chk("pre-xchg", 32'(f_out), 32'(4'b0001));
    step(0, 1, 4'b1111, 4'b1111, 0, 1, 1);
    chk_state("xchg", 4'b1000, 3'd1, 0, 0, 0);
    step(0, 0, 4'b0000, 4'b0000, 0, 0, 1);
    chk_state("pop after xchg", 4'b0001, 3'd0, 0, 1, 0);

    step(0, 1, 4'b1111, 4'b0010, 0, 1, 0);
    step(0, 1, 4'b1111, 4'b0100, 0, 1, 0);
    step(0, 1, 4'b1111, 4'b1000, 0, 1, 0);
    chk_state("push3", 4'b1000, 3'd3, 0, 0, 0);
    step(0, 1, 4'b1111, 4'b1111, 0, 1, 0);
    chk_state("push4 full", 4'b1111, 3'd4, 1, 0, 0);
    step(0, 1, 4'b1111, 4'b0000, 0, 1, 0);
    chk_state("push5 overflow", 4'b0000, 3'd4, 1, 0, 1);
    step(0, 0, 4'b0000, 4'b0000, 0, 0, 1);
    chk_state("lifo pop1", 4'b1000, 3'd3, 0, 0, 1);
    step(0, 0, 4'b0000, 4'b0000, 0, 0, 1);
    chk_state("lifo pop2", 4'b0100, 3'd2, 0, 0, 1);
    step(0, 0, 4'b0000, 4'b0000, 0, 0, 1);
    chk_state("lifo pop3", 4'b0010, 3'd1, 0, 0, 1);
    step(0, 0, 4'b0000, 4'b0000, 0, 0, 1);
    chk_state("lifo pop4", 4'b0001, 3'd0, 0, 1, 1);
    step(0, 0, 4'b0000, 4'b0000, 0, 0, 1);
    chk_state("pop empty", 4'b0001, 3'd0, 0, 1, 1);
    step(0, 1, 4'b1111, 4'b0110, 0, 0, 1);
    chk_state("pop empty update", 4'b0110, 3'd0, 0, 1, 1);
    step(0, 0, 4'b0000, 4'b0000, 0, 1, 1);
    chk_state("xchg empty", 4'b0110, 3'd0, 0, 1, 1);

    step(0, 0, 4'b0000, 4'b0000, 0, 1, 0);
    step(0, 0, 4'b0000, 4'b0000, 0, 1, 0);
    chk_state("pre-reset", 4'b0110, 3'd2, 0, 0, 1);
    step(1, 0, 4'b0000, 4'b0000, 0, 1, 0);
    chk_state("reset w/ push", 4'b0000, 3'd0, 0, 1, 0);
    step(0, 0, 4'b0000, 4'b0000, 0, 0, 1);
    chk_state("pop after reset", 4'b0000, 3'd0, 0, 1, 1);

    step(1, 0, 4'b0000, 4'b0000, 0, 0, 0);
    step(0, 1, 4'b1111, 4'b0010, 0, 0, 0);
    chk("sticky set", 32'(s_out), 32'(4'b0010));
    step(0, 1, 4'b1111, 4'b0000, 0, 0, 0);
    chk("sticky hold", 32'(s_out), 32'(4'b0010));
    chk("nonsticky overwrite", 32'(f_out), 32'(4'b0000));
    step(0, 1, 4'b1111, 4'b1001, 0, 0, 0);
    chk("sticky or", 32'(s_out), 32'(4'b1011));
    step(0, 0, 4'b0000, 4'b0000, 1, 0, 0);
    chk("clear sticky", 32'(s_out), 32'(4'b1001));
    chk("clear nonsticky dut", 32'(f_out), 32'(4'b1001));
    step(0, 1, 4'b0010, 4'b0010, 1, 0, 0);
    chk("clear then or", 32'(s_out), 32'(4'b1011));
    step(0, 1, 4'b1101, 4'b0000, 1, 0, 0);
    chk("clear unmasked sticky", 32'(s_out), 32'(4'b0000));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/flag_stack.md
FLAG_STACK -- requirements
Module: flag_stack

Interface
REQ-001 Parameter NUM_FLAGS, default 4, SHALL set the number of condition flags; bit 3 zero, bit 2 negative, bit 1 overflow, bit 0 carryout when 4.
REQ-002 Parameter DEPTH, default 4, SHALL set the number of save-stack entries (min 1).
REQ-003 Parameter STICKY_MASK, default all-zero, width NUM_FLAGS, SHALL mark flags that accumulate (OR) rather than overwrite.
REQ-004 The module SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 flagsIn  input  NUM_FLAGS  new flag values from the ALU.
REQ-008 setFlags  input  1  global write enable for flag update.
REQ-009 flagMask  input  NUM_FLAGS  per-flag write enable, ANDed with setFlags.
REQ-010 clearSticky  input  1  clear all STICKY_MASK flags.
REQ-011 push  input  1  save current flags to stack.
REQ-012 pop  input  1  restore flags from top of stack.
REQ-013 flagsOut  output  NUM_FLAGS  registered current flags.
REQ-014 depthCount  output  $clog2(DEPTH+1)  number of valid stack entries.
REQ-015 full  output  1  depthCount == DEPTH (combinational from count).
REQ-016 empty  output  1  depthCount == 0 (combinational from count).
REQ-017 stackErr  output  1  sticky flag: illegal push or pop occurred.

Function
REQ-018 All state changes SHALL occur on the rising clk edge; results visible on flagsOut the following cycle (1-cycle latency).
REQ-019 Flag update: for each i with setFlags & flagMask[i], non-sticky flag <= flagsIn[i]; sticky flag <= flag | flagsIn[i]; unmasked flags hold.
REQ-020 clearSticky SHALL zero every STICKY_MASK flag; with setFlags same cycle, masked sticky flags take flagsIn[i] (clear then OR), unmasked sticky flags become 0.
REQ-021 Push (push & ~pop, not full): entry[depthCount] <= flagsOut value before this edge; depthCount += 1; flag update per REQ-019/020 still applies.
REQ-022 Pop (pop & ~push, not empty): flagsOut <= entry[depthCount-1]; depthCount -= 1; pop SHALL override setFlags and clearSticky that cycle.
REQ-023 Push & pop, not empty: exchange -- flagsOut <= top entry, top entry <= pre-edge flagsOut; depthCount unchanged; setFlags/clearSticky ignored.
REQ-024 Push when full: stack and depthCount unchanged, stackErr <= 1, flag update proceeds.
REQ-025 Pop (alone or with push) when empty: stack and depthCount unchanged, stackErr <= 1, flag update proceeds.
REQ-026 stackErr SHALL remain 1 until reset; no other input clears it.
REQ-027 depthCount SHALL never exceed DEPTH nor wrap below 0.
REQ-028 Entries above depthCount SHALL never be observable on flagsOut.

Reset
REQ-029 reset SHALL take priority over all other inputs in the same cycle.
REQ-030 On reset: flagsOut = 0, depthCount = 0, empty = 1, full = 0, stackErr = 0; stack entry contents unspecified.
REQ-031 Reset asserted mid-sequence (e.g. with push) SHALL discard the operation; next cycle shows reset values only.

Verification
REQ-032 Defaults; setFlags=1, flagMask=4'b1111, flagsIn=4'b1010 -> next cycle flagsOut=4'b1010; then flagMask=4'b0001, flagsIn=4'b0101 -> flagsOut=4'b1011.
REQ-033 STICKY_MASK=4'b0010: flagsIn 4'b0010 then 4'b0000 with full mask -> flag bit1 stays 1; clearSticky -> bit1=0.
REQ-034 flags=4'b1100, push; set flags 4'b0011; pop -> flagsOut=4'b1100, depthCount 1->0, empty=1, stackErr=0.
REQ-035 DEPTH=4: five pushes -> depthCount=4, full=1, stackErr=1 after 5th; four pops restore in LIFO order; fifth pop -> stackErr stays 1, flagsOut unchanged.
REQ-036 flags=4'b0001, one entry 4'b1000, push&pop together -> flagsOut=4'b1000, top entry=4'b0001, depthCount=1; pop -> flagsOut=4'b0001.
REQ-037 With depthCount=2, stackErr=1, assert reset with push=1 -> next cycle all outputs at REQ-030 values.
